// File: rtl/bpred.sv
// bpred: static-decode + BHT conditional-branch predictor for the pc stage
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     pc, instr, instr_valid fetch-side lookup inputs
//     stall                 freezes table and counter updates
//     pr_taken, pr_offs     same-cycle prediction and B-type immediate
//     ex_br_*               EX-stage resolution of a conditional branch
//     pr_miss, br_addr      mispredict flag and corrected next PC
//     n_branches, n_misses  wrapping performance counters
module bpred #(
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      pc,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   input  logic             stall,
   output logic             pr_taken,
   output logic [12:0]      pr_offs,
   input  logic             ex_br_valid,
   input  logic [63:0]      ex_br_pc,
   input  logic             ex_br_taken,
   input  logic             ex_br_pred,
   input  logic [63:0]      ex_br_target,
   output logic             pr_miss,
   output logic [63:0]      br_addr,
   output logic [CNT_W-1:0] n_branches,
   output logic [CNT_W-1:0] n_misses
);
   localparam int IW = $clog2(BHT_ENTRIES);
   logic [1:0]    bht [BHT_ENTRIES];
   logic [IW-1:0] idx, tidx;
   logic [1:0]    cur, nxt_cnt;
   logic          is_br, unused_ok;
   assign idx       = pc[IW+1:2];
   assign tidx      = ex_br_pc[IW+1:2];
   assign is_br     = instr_valid && (instr[6:0] == 7'b1100011);
   assign pr_taken  = is_br && bht[idx][1];
   assign pr_offs   = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign pr_miss   = ex_br_valid && (ex_br_taken != ex_br_pred);
   assign br_addr   = ex_br_taken ? ex_br_target : ex_br_pc + 64'd4;
   assign cur       = bht[tidx];
   assign nxt_cnt   = ex_br_taken ? ((cur == 2'b11) ? cur : cur + 2'b01)
                                  : ((cur == 2'b00) ? cur : cur - 2'b01);
   assign unused_ok = ^{pc[63:IW+2], pc[1:0], instr[24:12]};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
         n_branches <= '0;
         n_misses   <= '0;
      end else if (ex_br_valid && !stall) begin
         bht[tidx]  <= nxt_cnt;
         n_branches <= n_branches + 1'b1;
         n_misses   <= n_misses + CNT_W'(pr_miss);
      end
   end
endmodule
